// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Decode-stage forwarding and load-use hazard unit. It keeps a short shadow of
// the three instructions ahead of decode (S1 = one stage ahead, S2 = two,
// S3 = three) and uses it to produce the operand-mux select codes that travel
// with the instruction into ID/EX. A load sitting directly ahead of a consumer
// cannot forward in time, so decode is stalled for one cycle and the consumer
// then picks the load data up from MEM/WB.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst_n         synchronous active-low reset
//   id_valid      decode holds a valid instruction
//   id_rs1/rs2    source register addresses
//   id_rs1_used   rs1 is really read by the instruction
//   id_rs2_used   rs2 is really read by the instruction
//   id_rd         destination register address
//   id_rd_we      instruction writes id_rd
//   id_is_load    instruction is a load
//   flush         kill the decode instruction, a bubble enters the pipeline
//   fwd_sel_a/b   operand mux selects: 00 regfile, 01 EX/MEM, 10 MEM/WB,
//                 11 writeback
//   stall         hold PC and IF/ID, ID/EX captures a bubble
//   stall_cnt     saturating count of stall cycles
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int reg_addr_w = 5,
    parameter int cnt_w      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [reg_addr_w-1:0] id_rs1,
    input  logic [reg_addr_w-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [reg_addr_w-1:0] id_rd,
    input  logic                  id_rd_we,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  stall,
    output logic [cnt_w-1:0]      stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b01;
    localparam logic [1:0] SEL_MWB = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    // Slot index 0 is S1 (nearest to decode), 2 is S3.
    logic [2:0]            slot_v;
    logic [2:0]            slot_we;
    logic [2:0]            slot_ld;
    logic [reg_addr_w-1:0] slot_rd [0:2];

    logic [2:0]            prod;
    logic                  s1_load_prod;
    logic                  load_hit;
    logic                  stall_int;
    logic                  sel_quiet;
    logic                  s1_load_en;

    // Nearest producing slot wins; register 0 never forwards (handled in prod).
    function automatic logic [1:0] nearest_sel(
        input logic [reg_addr_w-1:0] src,
        input logic [2:0]            p,
        input logic [reg_addr_w-1:0] rd1,
        input logic [reg_addr_w-1:0] rd2,
        input logic [reg_addr_w-1:0] rd3
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (p[0] && rd1 == src) begin
            sel = SEL_EXM;
        end else if (p[1] && rd2 == src) begin
            sel = SEL_MWB;
        end else if (p[2] && rd3 == src) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            prod[i] = slot_v[i] & slot_we[i] & (slot_rd[i] != '0);
        end
    end

    assign s1_load_prod = prod[0] & slot_ld[0];

    assign load_hit = s1_load_prod &
                      ((id_rs1_used & (id_rs1 == slot_rd[0])) |
                       (id_rs2_used & (id_rs2 == slot_rd[0])));

    // Flush outranks the stall; reset silences everything combinationally.
    assign stall_int = rst_n & id_valid & ~flush & load_hit;
    assign stall     = stall_int;

    // While stalling, the instruction is not issued, so its selects are moot
    // and forced to the register file code.
    assign sel_quiet = ~rst_n | ~id_valid | flush | stall_int;

    always_comb begin
        fwd_sel_a = SEL_RF;
        fwd_sel_b = SEL_RF;
        if (!sel_quiet && id_rs1_used) begin
            fwd_sel_a = nearest_sel(id_rs1, prod, slot_rd[0], slot_rd[1], slot_rd[2]);
        end
        if (!sel_quiet && id_rs2_used) begin
            fwd_sel_b = nearest_sel(id_rs2, prod, slot_rd[0], slot_rd[1], slot_rd[2]);
        end
    end

    assign s1_load_en = id_valid & ~stall_int & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_v    <= '0;
            stall_cnt <= '0;
        end else begin
            slot_v[2]  <= slot_v[1];
            slot_we[2] <= slot_we[1];
            slot_ld[2] <= slot_ld[1];
            slot_rd[2] <= slot_rd[1];

            slot_v[1]  <= slot_v[0];
            slot_we[1] <= slot_we[0];
            slot_ld[1] <= slot_ld[0];
            slot_rd[1] <= slot_rd[0];

            // Fields load unconditionally; only the valid bit marks a bubble.
            slot_v[0]  <= s1_load_en;
            slot_we[0] <= id_rd_we;
            slot_ld[0] <= id_is_load;
            slot_rd[0] <= id_rd;

            if (stall_int && (stall_cnt != {cnt_w{1'b1}})) begin
                stall_cnt <= stall_cnt + cnt_w'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_rd_we, id_is_load, flush;
    logic [1:0] fwd_sel_a, fwd_sel_b, sm_sel_a, sm_sel_b;
    logic       stall, sm_stall;
    logic [15:0] stall_cnt;
    logic [4:0]  sm_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the last three issued instructions, index d = distance.
    logic       m_v  [1:3];
    logic       m_we [1:3];
    logic       m_ld [1:3];
    logic [4:0] m_rd [1:3];
    int         m_cnt;

    fwd_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .flush(flush), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    fwd_hazard_unit #(.reg_addr_w(5), .cnt_w(5)) dut_sm (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .flush(flush), .fwd_sel_a(sm_sel_a), .fwd_sel_b(sm_sel_b),
        .stall(sm_stall), .stall_cnt(sm_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_stall();
        if (!rst_n || !id_valid || flush) return 1'b0;
        if (!(m_v[1] && m_we[1] && m_ld[1] && m_rd[1] != 5'd0)) return 1'b0;
        return (id_rs1_used && id_rs1 == m_rd[1]) || (id_rs2_used && id_rs2 == m_rd[1]);
    endfunction

    // Code equals the distance to the nearest in-flight writer of src.
    function automatic logic [1:0] model_sel(input logic [4:0] src, input logic used);
        if (!rst_n || !id_valid || flush || !used || model_stall()) return 2'b00;
        for (int d = 1; d <= 3; d++) begin
            if (m_v[d] && m_we[d] && m_rd[d] != 5'd0 && m_rd[d] == src) return 2'(d);
        end
        return 2'b00;
    endfunction

    task automatic set_in(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic we, input logic ld, input logic fl);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_rd_we = we; id_is_load = ld; flush = fl;
    endtask

    task automatic bubble();
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Let combinational outputs settle and compare against the model.
    task automatic settle();
        #2;
        chk("sel_a", 32'(fwd_sel_a), 32'(model_sel(id_rs1, id_rs1_used)));
        chk("sel_b", 32'(fwd_sel_b), 32'(model_sel(id_rs2, id_rs2_used)));
        chk("stall", 32'(stall), 32'(model_stall()));
        chk("cnt16", 32'(stall_cnt), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
        chk("cnt5", 32'(sm_cnt), (m_cnt > 31) ? 32'd31 : 32'(m_cnt));
        chk("sm_stall", 32'(sm_stall), 32'(model_stall()));
    endtask

    task automatic advance();
        logic st;
        @(posedge clk);
        st = model_stall();
        if (!rst_n) begin
            for (int d = 1; d <= 3; d++) m_v[d] = 1'b0;
            m_cnt = 0;
        end else begin
            for (int d = 3; d >= 2; d--) begin
                m_v[d] = m_v[d-1]; m_we[d] = m_we[d-1];
                m_ld[d] = m_ld[d-1]; m_rd[d] = m_rd[d-1];
            end
            m_v[1] = id_valid && !st && !flush;
            m_we[1] = id_rd_we; m_ld[1] = id_is_load; m_rd[1] = id_rd;
            if (st) m_cnt++;
        end
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bubble();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int d = 1; d <= 3; d++) begin
            m_v[d] = 1'b0; m_we[d] = 1'b0; m_ld[d] = 1'b0; m_rd[d] = 5'd0;
        end
        m_cnt = 0;
        rst_n = 1'b0;
        bubble();
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        settle();
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        advance();

        // Back-to-back ALU
        set_in(1, 0, 0, 0, 0, 5, 1, 0, 0); step();
        set_in(1, 5, 1, 0, 0, 0, 0, 0, 0); settle();
        chk("b2b_sel_a", 32'(fwd_sel_a), 32'd1);
        chk("b2b_stall", 32'(stall), 32'd0);
        advance();

        // Distance sweep
        bubble(); step(); step(); step();
        set_in(1, 0, 0, 0, 0, 7, 1, 0, 0); step();
        bubble(); step();
        set_in(1, 0, 0, 7, 1, 0, 0, 0, 0); settle();
        chk("dist2_b", 32'(fwd_sel_b), 32'd2); advance();
        settle(); chk("dist3_b", 32'(fwd_sel_b), 32'd3); advance();
        settle(); chk("dist4_b", 32'(fwd_sel_b), 32'd0); advance();
        set_in(1, 0, 0, 0, 0, 7, 1, 0, 0); step();
        set_in(1, 0, 0, 0, 0, 7, 1, 0, 0); step();
        set_in(1, 0, 0, 7, 1, 0, 0, 0, 0); settle();
        chk("nearest_b", 32'(fwd_sel_b), 32'd1); advance();

        // Load-use
        do_reset();
        set_in(1, 0, 0, 0, 0, 3, 1, 1, 0); step();
        set_in(1, 3, 1, 0, 0, 0, 0, 0, 0); settle();
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_sel_a0", 32'(fwd_sel_a), 32'd0);
        advance();
        settle();
        chk("lu_stall2", 32'(stall), 32'd0);
        chk("lu_sel_a", 32'(fwd_sel_a), 32'd2);
        advance();
        settle();
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        advance();

        // Register zero and unused source
        bubble(); step(); step(); step();
        set_in(1, 0, 0, 0, 0, 0, 1, 1, 0); step();
        set_in(1, 0, 1, 0, 1, 0, 0, 0, 0); settle();
        chk("r0_sel_a", 32'(fwd_sel_a), 32'd0);
        chk("r0_stall", 32'(stall), 32'd0);
        advance();
        set_in(1, 0, 0, 0, 0, 9, 1, 0, 0); step();
        set_in(1, 0, 0, 9, 0, 0, 0, 0, 0); settle();
        chk("unused_b", 32'(fwd_sel_b), 32'd0);
        advance();

        // Flush versus stall
        bubble(); step(); step(); step();
        set_in(1, 0, 0, 0, 0, 4, 1, 1, 0); step();
        set_in(1, 4, 1, 4, 1, 0, 0, 0, 1); settle();
        chk("fl_stall", 32'(stall), 32'd0);
        chk("fl_sel_a", 32'(fwd_sel_a), 32'd0);
        advance();
        set_in(1, 4, 1, 0, 0, 0, 0, 0, 0); settle();
        chk("fl_next_a", 32'(fwd_sel_a), 32'd2);
        chk("fl_next_stall", 32'(stall), 32'd0);
        advance();

        // Reset mid-stream
        bubble(); step(); step(); step();
        set_in(1, 0, 0, 0, 0, 6, 1, 1, 0); step();
        set_in(1, 6, 1, 0, 0, 0, 0, 0, 0); settle();
        chk("mid_pre_stall", 32'(stall), 32'd1);
        rst_n = 1'b0; settle();
        chk("mid_stall", 32'(stall), 32'd0);
        chk("mid_sel_a", 32'(fwd_sel_a), 32'd0);
        advance();
        rst_n = 1'b1; settle();
        chk("mid_cnt", 32'(stall_cnt), 32'd0);
        chk("mid_after_a", 32'(fwd_sel_a), 32'd0);
        advance();

        // Saturation: a load reading its own rd stalls every other cycle
        bubble(); step(); step(); step();
        set_in(1, 8, 1, 0, 0, 8, 1, 1, 0);
        for (int i = 0; i < 84; i++) step();
        bubble(); settle();
        chk("sat_cnt5", 32'(sm_cnt), 32'd31);
        chk("sat_cnt16", 32'(stall_cnt), 32'd42);
        advance();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            set_in($urandom_range(0, 9) != 0,
                   5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                   5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                   5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Tracks the destination registers of in-flight instructions and generates the 2-bit select codes for the two 4:1 operand-forwarding multiplexers at the execute-stage inputs. Also detects load-use hazards and stalls the decode stage for one cycle. Sits at decode. Its `fwd_sel_a`/`fwd_sel_b` outputs are captured into the ID/EX pipeline register together with the instruction and drive the operand muxes' `sel` inputs in the following cycle.

## Interface
- `reg_addr_w`, default 5: register address width.
- `cnt_w`, default 16: width of the stall-cycle counter.

- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `id_valid` in 1: a valid instruction is present in decode.
- `id_rs1`, `id_rs2` in `reg_addr_w`: source register addresses.
- `id_rs1_used`, `id_rs2_used` in 1: the source is actually read.
- `id_rd` in `reg_addr_w`: destination register address.
- `id_rd_we` in 1: the instruction writes `id_rd`.
- `id_is_load` in 1: the instruction is a load.
- `flush` in 1: kill the decode instruction; insert a bubble.
- `fwd_sel_a`, `fwd_sel_b` out 2: operand mux selects.
  - 00: register file.
  - 01: EX/MEM result.
  - 10: MEM/WB result, including load data.
  - 11: writeback data.
- `stall` out 1: hold PC and IF/ID; the ID/EX register captures a bubble.
- `stall_cnt` out `cnt_w`: saturating count of stall cycles.

## Operation
- Three tracking slots S1, S2, S3 model the instructions 1, 2 and 3 stages ahead of decode. Each slot holds `v`, `rd`, `we` and `ld`.
- Every cycle in which `rst_n` is 1:
  - S3 is loaded from S2, and S2 from S1.
  - S1 is loaded from the decode fields when `id_valid & ~stall & ~flush`. Otherwise S1 is loaded with a bubble (v=0).
- A slot is a forwarding producer when `v & we & (rd != 0)`. Register 0 is never forwarded and never causes a stall.
- Select generation per source X (A uses rs1, B uses rs2), combinational from the ID inputs and the slots:
  - If `~id_valid` or `~X_used`, the select is 00.
  - Otherwise the nearest matching producer wins: S1 gives 01, else S2 gives 10, else S3 gives 11, else 00.
- Load-use stall:
  - `stall` = `id_valid & ~flush & S1.v & S1.ld & S1.we & (S1.rd != 0)` and S1.rd matches any used source.
  - While `stall` is 1, both selects are forced to 00.
  - The stall lasts exactly one cycle. On the next cycle the load sits in S2 and the consumer receives 10.
- A load in S2 or S3 never stalls.
- `flush` has priority over `stall`. When `flush` is 1, `stall` is 0, both selects are 00, and a bubble is inserted.
- `stall_cnt` increments by 1 on each cycle where `stall` is 1 and holds at all-ones. It is not cleared except by reset.

## Timing
- Reset: when `rst_n` is 0 at a rising edge, all slot `v` bits and `stall_cnt` are cleared. While `rst_n` is low, `stall` is forced to 0 and both selects to 00, regardless of the inputs.
- A reset in the middle of a stall aborts the stall. The first cycle after reset sees empty slots.
- Select and stall latency: both are combinational and valid in the same cycle as the decode inputs. Pipeline state has a one-cycle update latency.
- A producer in decode at cycle t is seen as S1 at t+1, S2 at t+2 and S3 at t+3. It is invisible from t+4.
- When `rs1 == rs2` and a match exists, both selects carry the same code.
- When several slots match, only the nearest is used.
- `stall_cnt` updates on the edge that follows the stall cycle.

## Test plan
- Back-to-back ALU: at t, decode `rd=5, we=1`. At t+1, decode `rs1=5` used. Expected: `fwd_sel_a=01`, `stall=0`.
- Distance sweep:
  - Producer `rd=7`, then consumers reading `rs2=7` at distances 2, 3 and 4. Expected `fwd_sel_b` = 10, 11, 00.
  - Add a second writer of `rd=7` at distance 1. Expected `fwd_sel_b=01`.
- Load-use:
  - At t, a load with `rd=3`. At t+1, a consumer with `rs1=3`. Expected: `stall=1` and selects 00 at t+1; `stall=0` and `fwd_sel_a=10` at t+2; `stall_cnt=1`.
- Register zero and unused source:
  - A producer with `rd=0`, followed by a consumer with `rs1=0`. Expected: select 00 and no stall.
  - `rs2` matches but `id_rs2_used=0`. Expected: `fwd_sel_b=00`.
- Flush versus stall:
  - A load-use condition with `flush=1` in the same cycle. Expected: `stall=0` and a bubble in S1.
  - Next cycle, a consumer of that load's rd. Expected: select 10 with no stall, because the load itself was already in flight.
- Reset mid-stream:
  - Assert `rst_n=0` for one cycle during a load-use stall. Expected: `stall=0` immediately and `stall_cnt=0`.
  - Next cycle, a consumer of the old rd. Expected: select 00.
  - Saturation: preload 65535 stall cycles with `cnt_w=16`. Expected: `stall_cnt` stays at 0xFFFF.
